// File: rtl/key_event_module.sv
// Key event classifier: turns a debounced key level into press, short, long,
// auto-repeat and release pulses, timed by a 1 ms prescaled tick.
module key_event_module #(
    parameter logic [15:0] T1MS    = 16'd6,
    parameter logic [7:0]  LONG_MS = 8'd20,
    parameter logic [7:0]  REP_MS  = 8'd5
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Key_In,
    output logic Press_Pulse,
    output logic Short_Pulse,
    output logic Long_Pulse,
    output logic Repeat_Pulse,
    output logic Release_Pulse,
    output logic Long_Sig
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic        k_d;
    logic [15:0] presc, presc_nx;
    logic [7:0]  ms_cnt, ms_nx, ms_inc;
    logic        rise, fall, tick;
    logic        press_nx, short_nx, long_nx, repeat_nx, release_nx, long_sig_nx;

    always_comb begin
        rise   = Key_In & ~k_d;
        fall   = ~Key_In & k_d;
        tick   = (presc == T1MS - 16'd1);
        ms_inc = ms_cnt + 8'd1;

        state_nx    = state;
        presc_nx    = tick ? '0 : presc + 16'd1;
        ms_nx       = tick ? ms_inc : ms_cnt;
        press_nx    = 1'b0;
        short_nx    = 1'b0;
        long_nx     = 1'b0;
        repeat_nx   = 1'b0;
        release_nx  = 1'b0;
        long_sig_nx = 1'b0;

        unique case (state)
            IDLE: begin
                presc_nx = '0;
                ms_nx    = '0;
                if (rise) begin
                    state_nx = PRESSED;
                    press_nx = 1'b1;
                end
            end
            PRESSED: begin
                // A release on the threshold cycle wins over the long-press.
                if (fall) begin
                    state_nx   = IDLE;
                    short_nx   = 1'b1;
                    release_nx = 1'b1;
                    presc_nx   = '0;
                    ms_nx      = '0;
                end else if (tick && (ms_inc == LONG_MS)) begin
                    state_nx = HOLD;
                    long_nx  = 1'b1;
                    ms_nx    = '0;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_nx   = IDLE;
                    release_nx = 1'b1;
                    presc_nx   = '0;
                    ms_nx      = '0;
                end else begin
                    long_sig_nx = 1'b1;
                    if (tick && (ms_inc == REP_MS)) begin
                        repeat_nx = 1'b1;
                        ms_nx     = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                presc_nx = '0;
                ms_nx    = '0;
            end
        endcase
    end

    // k_d resets high so a key already held at reset release is not a press.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= IDLE;
            k_d           <= 1'b1;
            presc         <= '0;
            ms_cnt        <= '0;
            Press_Pulse   <= 1'b0;
            Short_Pulse   <= 1'b0;
            Long_Pulse    <= 1'b0;
            Repeat_Pulse  <= 1'b0;
            Release_Pulse <= 1'b0;
            Long_Sig      <= 1'b0;
        end else begin
            state         <= state_nx;
            k_d           <= Key_In;
            presc         <= presc_nx;
            ms_cnt        <= ms_nx;
            Press_Pulse   <= press_nx;
            Short_Pulse   <= short_nx;
            Long_Pulse    <= long_nx;
            Repeat_Pulse  <= repeat_nx;
            Release_Pulse <= release_nx;
            Long_Sig      <= long_sig_nx;
        end
    end

endmodule

// File: doc/key_event_module.md
KEY_EVENT_MODULE -- requirements
Module: key_event_module

Interface
REQ-001 SHALL have parameter T1MS, default 16'd6: CLK cycles per 1 ms tick; legal range 1..65535.
REQ-002 SHALL have parameter LONG_MS, default 8'd20: tick count from press to long-press; legal range 1..255.
REQ-003 SHALL have parameter REP_MS, default 8'd5: tick count between auto-repeat pulses; legal range 1..255.
REQ-004 SHALL have port CLK  input  1: the single clock; all state updates on posedge CLK.
REQ-005 SHALL have port RSTn  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port Key_In  input  1: debounced key level from the upstream debounce stage's Pin_Out; 1 = pressed; synchronous to CLK.
REQ-007 SHALL have port Press_Pulse  output  1: one-cycle pulse on each press.
REQ-008 SHALL have port Short_Pulse  output  1: one-cycle pulse on release before the long-press threshold.
REQ-009 SHALL have port Long_Pulse  output  1: one-cycle pulse when the long-press threshold is reached.
REQ-010 SHALL have port Repeat_Pulse  output  1: one-cycle auto-repeat pulse while held past long-press.
REQ-011 SHALL have port Release_Pulse  output  1: one-cycle pulse on every release that follows a recognised press.
REQ-012 SHALL have port Long_Sig  output  1: level, high while in state HOLD.

Function
REQ-013 SHALL register Key_In into k_d each cycle; rise = Key_In & ~k_d, fall = ~Key_In & k_d.
REQ-014 SHALL implement states IDLE, PRESSED, HOLD; all outputs registered.
REQ-015 IDLE: on rise -> PRESSED, Press_Pulse=1 next cycle (cycle 0), prescaler and ms counter cleared; fall in IDLE SHALL produce no pulse.
REQ-016 Prescaler (16-bit) SHALL count 0..T1MS-1 only outside IDLE; one ms tick each time it wraps to 0.
REQ-017 ms counter (8-bit) SHALL increment per tick; it SHALL clear on entry to PRESSED and on each threshold match.
REQ-018 PRESSED: when ms counter reaches LONG_MS -> HOLD, Long_Pulse=1 at cycle LONG_MS*T1MS; no Repeat_Pulse on that cycle.
REQ-019 HOLD: Repeat_Pulse=1 at cycles LONG_MS*T1MS + k*REP_MS*T1MS, k>=1, for as long as Key_In stays 1.
REQ-020 Fall in PRESSED SHALL give Short_Pulse=1 and Release_Pulse=1 in the same cycle, -> IDLE.
REQ-021 Fall in HOLD SHALL give Release_Pulse=1 only, Long_Sig=0 in that cycle, -> IDLE.
REQ-022 Fall coincident with LONG threshold SHALL be treated as release in PRESSED: Short+Release, no Long_Pulse.
REQ-023 Fall coincident with a repeat threshold SHALL give Release_Pulse only, no Repeat_Pulse.
REQ-024 Rise one cycle after a release SHALL be accepted as a new press (IDLE needs no dwell).
REQ-025 Every pulse output SHALL be high for exactly one cycle per event; Press_Pulse and Release_Pulse never high together.

Reset
REQ-026 RSTn=0 SHALL immediately force state IDLE, prescaler=0, ms counter=0, all outputs 0.
REQ-027 k_d SHALL reset to 1, so a key held through reset release gives no pulses until released and pressed again.
REQ-028 Reset asserted mid-press or in HOLD SHALL abort with no Release_Pulse, Short_Pulse or Repeat_Pulse.

Verification (defaults T1MS=6, LONG_MS=20, REP_MS=5)
REQ-029 Key_In high 50 cycles then low -> Press_Pulse at cycle 0; Short_Pulse+Release_Pulse at release; no Long_Pulse.
REQ-030 Key_In high 200 cycles -> Long_Pulse at 120, Long_Sig high from 121; Repeat_Pulse at 150 and 180; Release_Pulse at release.
REQ-031 Release sampled exactly at cycle 120 -> Short_Pulse+Release_Pulse, Long_Pulse never asserted, Long_Sig stays 0.
REQ-032 Key_In=1 during and after RSTn release -> no pulses; then low 3 cycles, high -> Press_Pulse once.
REQ-033 RSTn pulsed low at cycle 140 while held -> outputs 0 asynchronously; no Release_Pulse on later release.
REQ-034 Release then re-press after 1 low cycle -> Release_Pulse then Press_Pulse 2 cycles apart; Long_Pulse 120 cycles after second press.
